led_blink_scheduler: RTL and testbench

LED_BLINK_SCHEDULER -- requirements
Module: led_blink_scheduler

---
 rtl/led_pkg.sv | 18 +
 rtl/rr_arbiter.sv | 27 ++
 rtl/led_blink_scheduler.sv | 157 +++++++++++++++
 tb/tb_led_blink_scheduler.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// led_pkg: shared types and defaults for the LED blink scheduler.
package led_pkg;

  // Scheduler states: waiting, LED lit, LED dark, job finished.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2,
    DONE = 2'd3
  } led_state_e;

  // Default LED on-time and off-time, in clock cycles.
  localparam int HALF_PERIOD_DEFAULT = 16;

  // Largest supported number of requesters.
  localparam int NREQ_MAX = 8;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick. The requester at index 'ptr'
// has highest priority, and priority falls with increasing index, wrapping
// modulo NREQ. The result is one-hot, or zero when nothing requests.
module rr_arbiter #(
  parameter int NREQ  = 4,
  parameter int PTR_W = 2
) (
  input  logic [NREQ-1:0]  req,
  input  logic [PTR_W-1:0] ptr,
  output logic [NREQ-1:0]  grant
);

  logic [2*NREQ-1:0] dbl_req;
  logic [2*NREQ-1:0] dbl_gnt;
  logic [NREQ-1:0]   rot_req;
  logic [NREQ-1:0]   rot_gnt;

  // Rotate so 'ptr' lands on bit 0, keep the lowest set bit, rotate back.
  always_comb begin
    dbl_req = {req, req} >> ptr;
    rot_req = dbl_req[NREQ-1:0];
    rot_gnt = rot_req & (~rot_req + NREQ'(1));
    dbl_gnt = {rot_gnt, rot_gnt} << ptr;
    grant   = dbl_gnt[2*NREQ-1:NREQ];
  end

endmodule

// File: rtl/led_blink_scheduler.sv
// led_blink_scheduler: shares one LED among NREQ requesters. Each granted
// requester gets its latched number of blinks (HALF_PERIOD cycles on, then
// HALF_PERIOD cycles off per blink), followed by a one-cycle DONE pulse.
// Optional build macro LED_BLINK_SCHED_ABORT_EN adds input i_abort, which
// cuts a running job short and jumps to DONE.
module led_blink_scheduler
  import led_pkg::*;
#(
  parameter int NREQ        = 4,
  parameter int HALF_PERIOD = HALF_PERIOD_DEFAULT,
  parameter int CNT_W       = 4
) (
  input  logic                  clk,
  input  logic                  i_reset,
`ifdef LED_BLINK_SCHED_ABORT_EN
  input  logic                  i_abort,
`endif
  input  logic [NREQ-1:0]       i_req,
  input  logic [NREQ*CNT_W-1:0] i_count,
  output logic [NREQ-1:0]       o_grant,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_led
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int PH_W  = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;

  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(HALF_PERIOD - 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NREQ - 1);

  led_state_e       state_q, state_d;
  logic [PH_W-1:0]  phase_q, phase_d;
  logic [CNT_W-1:0] rem_q,   rem_d;
  logic [NREQ-1:0]  grant_q, grant_d;
  logic [PTR_W-1:0] ptr_q,   ptr_d;

  logic [NREQ-1:0]  win;
  logic [PTR_W-1:0] win_idx;
  logic [PTR_W-1:0] win_next_ptr;
  logic [CNT_W-1:0] win_cnt;
  logic             phase_end;
  logic             abort_hit;

  rr_arbiter #(
    .NREQ  (NREQ),
    .PTR_W (PTR_W)
  ) u_rr_arbiter (
    .req   (i_req),
    .ptr   (ptr_q),
    .grant (win)
  );

`ifdef LED_BLINK_SCHED_ABORT_EN
  assign abort_hit = i_abort;
`else
  assign abort_hit = 1'b0;
`endif

  assign phase_end = (phase_q == PH_LAST);

  // Turn the one-hot winner into an index and select that requester's count.
  always_comb begin
    win_idx = '0;
    win_cnt = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (win[k]) begin
        win_idx = PTR_W'(k);
        win_cnt = i_count[k*CNT_W +: CNT_W];
      end
    end
    win_next_ptr = (win_idx == PTR_LAST) ? '0 : win_idx + PTR_W'(1);
  end

  // Next-state, phase, remaining-count, grant and pointer logic.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    rem_d   = rem_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      IDLE: begin
        if (|i_req) begin
          // Count is sampled only here; later i_count changes are ignored.
          grant_d = win;
          ptr_d   = win_next_ptr;
          rem_d   = win_cnt;
          phase_d = '0;
          state_d = (win_cnt == '0) ? DONE : ON;
        end
      end
      ON: begin
        if (abort_hit) begin
          phase_d = '0;
          rem_d   = '0;
          state_d = DONE;
        end else if (phase_end) begin
          phase_d = '0;
          state_d = OFF;
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end
      OFF: begin
        if (abort_hit) begin
          phase_d = '0;
          rem_d   = '0;
          state_d = DONE;
        end else if (phase_end) begin
          // One blink finished; stop after the last one.
          phase_d = '0;
          rem_d   = rem_q - CNT_W'(1);
          state_d = (rem_q == CNT_W'(1)) ? DONE : ON;
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end
      DONE: begin
        grant_d = '0;
        state_d = IDLE;
      end
      default: begin
        grant_d = '0;
        phase_d = '0;
        rem_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // State and counter registers; reset aborts any job immediately.
  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= IDLE;
      phase_q <= '0;
      rem_q   <= '0;
      grant_q <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      rem_q   <= rem_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
    end
  end

  // Outputs decode straight from registered state so reset clears them at once.
  always_comb begin
    o_grant = grant_q;
    o_busy  = (state_q != IDLE);
    o_done  = (state_q == DONE);
    o_led   = (state_q == ON);
  end

endmodule

// File: tb/tb_led_blink_scheduler.sv
// tb_led_blink_scheduler: table-driven job vectors, hand-written corner
// sequences and a randomized run against a job-timeline reference model.
module tb_led_blink_scheduler;

  localparam int NREQ = 4;
  localparam int HP   = 16;
  localparam int CW   = 4;

  logic             clk;
  logic             i_reset;
  logic             i_abort;
  logic [NREQ-1:0]  i_req;
  logic [NREQ*CW-1:0] i_count;
  logic [NREQ-1:0]  o_grant;
  logic             o_busy;
  logic             o_done;
  logic             o_led;

  int n_checks = 0;
  int n_pass   = 0;

  led_blink_scheduler #(
    .NREQ        (NREQ),
    .HALF_PERIOD (HP),
    .CNT_W       (CW)
  ) dut (
    .clk     (clk),
    .i_reset (i_reset),
`ifdef LED_BLINK_SCHED_ABORT_EN
    .i_abort (i_abort),
`endif
    .i_req   (i_req),
    .i_count (i_count),
    .o_grant (o_grant),
    .o_busy  (o_busy),
    .o_done  (o_done),
    .o_led   (o_led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a job is (owner, N, elapsed t); it lasts 2*N*HP+1 cycles.
  bit m_busy;
  int m_owner, m_n, m_t, m_ptr;

  function automatic void model_reset();
    m_busy = 0; m_owner = 0; m_n = 0; m_t = 0; m_ptr = 0;
  endfunction

  function automatic void model_step(input logic [3:0] req, input logic [15:0] cnt);
    if (!m_busy) begin
      for (int i = 0; i < NREQ; i++) begin
        int k;
        k = (m_ptr + i) % NREQ;
        if (req[k]) begin
          m_owner = k;
          m_n     = int'((cnt >> (4 * k)) & 16'hF);
          m_t     = 0;
          m_busy  = 1;
          m_ptr   = (k + 1) % NREQ;
          break;
        end
      end
    end else begin
      m_t++;
      if (m_t > 2 * m_n * HP) m_busy = 0;
    end
  endfunction

  function automatic logic [6:0] model_out();
    logic [3:0] g;
    if (!m_busy) return 7'd0;
    g = 4'(1 << m_owner);
    return {g, 1'b1, (m_t == 2 * m_n * HP),
            ((m_t < 2 * m_n * HP) && ((m_t / HP) % 2 == 0))};
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    i_req   = '0;
    i_count = '0;
    i_abort = 1'b0;
    tick();
    check("reset_outputs", {25'd0, o_grant, o_busy, o_done, o_led}, 32'd0);
    i_reset = 1'b0;
    model_reset();
  endtask

  // Issue one request, drop it after grant, then follow the job to IDLE.
  task automatic run_job(input string nm, input logic [3:0] req, input logic [15:0] cnt,
                         input logic [15:0] cnt_after, input logic [3:0] exp_g, input int n);
    int t, err, done_cnt;
    i_req   = req;
    i_count = cnt;
    tick();
    i_req   = '0;
    i_count = cnt_after;
    check({nm, "_grant"}, {28'd0, o_grant}, {28'd0, exp_g});
    t = 0; err = 0; done_cnt = 0;
    while (o_busy && t < 2000) begin
      if (o_grant !== exp_g) err++;
      if (o_led !== ((t < 2 * n * HP) && ((t / HP) % 2 == 0))) err++;
      if (o_done) begin
        done_cnt++;
        if (t != 2 * n * HP) err++;
      end
      t++;
      tick();
    end
    check({nm, "_len"}, t, 2 * n * HP + 1);
    check({nm, "_done_pulses"}, done_cnt, 1);
    check({nm, "_waveform_errs"}, err, 0);
  endtask

  typedef struct {
    logic [3:0]  req;
    logic [15:0] cnt;
    logic [15:0] cnt_after;
    logic [3:0]  exp_g;
    int          n;
  } vec_t;

  vec_t       tbl[6];
  logic [3:0] seen[$];
  logic [3:0] exp_seq[5];
  logic [3:0] prev_g;
  int         gap, max_gap, cyc;

  initial begin
    // Jobs run back to back from reset; the RR pointer carries across rows.
    tbl[0] = '{4'b0001, 16'h0002, 16'h0002, 4'b0001, 2};   // ptr 0 -> 1
    tbl[1] = '{4'b1001, 16'h1111, 16'h1111, 4'b1000, 1};   // ptr 1 -> 0
    tbl[2] = '{4'b0110, 16'h1111, 16'h1111, 4'b0010, 1};   // ptr 0 -> 2
    tbl[3] = '{4'b0100, 16'h1011, 16'h1011, 4'b0100, 0};   // ptr 2 -> 3
    tbl[4] = '{4'b0011, 16'h111F, 16'h1111, 4'b0001, 15};  // ptr 3 -> 1
    tbl[5] = '{4'b1111, 16'h3333, 16'h3333, 4'b0010, 3};   // ptr 1 -> 2
    exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    i_reset = 1'b1; i_abort = 1'b0; i_req = '0; i_count = '0;
    #2;
    check("async_reset_idle", {28'd0, o_grant}, 32'd0);
    do_reset();

    for (int i = 0; i < 6; i++)
      run_job($sformatf("row%0d", i), tbl[i].req, tbl[i].cnt, tbl[i].cnt_after,
              tbl[i].exp_g, tbl[i].n);

    // All four requesting continuously: strict rotation, at most 1 idle cycle.
    do_reset();
    i_req = 4'b1111; i_count = 16'h1111;
    gap = 0; max_gap = 0; prev_g = '0; cyc = 0;
    while (seen.size() < 5 && cyc < 1000) begin
      tick();
      cyc++;
      if (o_grant != 4'd0 && prev_g == 4'd0) begin
        seen.push_back(o_grant);
        if (seen.size() > 1 && gap > max_gap) max_gap = gap;
        gap = 0;
      end else if (o_grant == 4'd0) begin
        gap++;
      end
      prev_g = o_grant;
    end
    for (int i = 0; i < 5; i++)
      check($sformatf("rr_order%0d", i),
            {28'd0, (i < seen.size()) ? seen[i] : 4'd0}, {28'd0, exp_seq[i]});
    check("rr_max_idle_gap", max_gap, 1);

    // Reset in the middle of ON clears outputs without a clock edge.
    do_reset();
    i_req = 4'b0100; i_count = 16'h0100;
    tick();
    i_req = '0;
    repeat (4) tick();
    check("mid_on_led", {31'd0, o_led}, 32'd1);
    i_reset = 1'b1;
    #1;
    check("async_reset_outs", {25'd0, o_grant, o_busy, o_done, o_led}, 32'd0);
    tick();
    i_reset = 1'b0;
    i_req = 4'b1111; i_count = 16'h0000;
    tick();
    check("post_reset_prio", {28'd0, o_grant}, 32'd1);
    check("post_reset_zero_cnt_done", {30'd0, o_done, o_led}, 32'd2);
    i_req = '0;
    tick();

`ifdef LED_BLINK_SCHED_ABORT_EN
    // Abort on the fifth ON cycle goes straight to DONE.
    do_reset();
    i_req = 4'b0001; i_count = 16'h0003;
    tick();
    i_req = '0;
    repeat (4) tick();
    i_abort = 1'b1;
    tick();
    i_abort = 1'b0;
    check("abort_done", {25'd0, o_grant, o_busy, o_done, o_led}, {25'd0, 4'b0001, 3'b110});
    tick();
    check("abort_idle", {31'd0, o_busy}, 32'd0);
    i_req = 4'b0011;
    tick();
    check("abort_ptr_adv", {28'd0, o_grant}, 32'd2);
    i_req = '0;
    repeat (3) tick();
`endif

    // Randomized traffic against the reference model.
    do_reset();
    for (int c = 0; c < 800; c++) begin
      i_req   = 4'($urandom_range(0, 15));
      i_count = {4'($urandom_range(0, 2)), 4'($urandom_range(0, 2)),
                 4'($urandom_range(0, 2)), 4'($urandom_range(0, 2))};
      @(posedge clk);
      model_step(i_req, i_count);
      #1;
      check($sformatf("rand_c%0d", c), {25'd0, o_grant, o_busy, o_done, o_led},
            {25'd0, model_out()});
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
